apb_uart_sched: RTL and testbench

Two-requester APB master and scheduler for the UART APB register slave. It accepts byte-level commands (set baud, transmit byte, receive byte) from two requesters and arbitrates between them round-robin. Before each access it checks the UART's TX/RX ready status, then runs a two-phase APB transfer and returns the read data or an error to the winning requester. It sits between the system-side requesters and the UART's APB slave port, and is the only APB master on that slave.

---
 rtl/apb_uart_pkg.sv | 36 +++
 rtl/apb_uart_sched_rr_arb2.sv | 26 ++
 rtl/apb_uart_sched.sv | 178 +++++++++++++++++
 tb/tb_apb_uart_sched.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB UART scheduler: op codes, UART register
// offsets, FSM state encoding and the default data width.
package apb_uart_pkg;

   localparam int DEF_BITWIDTH = 8;

   typedef enum logic [1:0] {
      OP_BAUD = 2'b00,
      OP_TX   = 2'b01,
      OP_RX   = 2'b10,
      OP_ILL  = 2'b11
   } op_t;

   localparam logic [7:0] REG_BAUD = 8'h00;
   localparam logic [7:0] REG_TX   = 8'h04;
   localparam logic [7:0] REG_RX   = 8'h08;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_RDY = 3'd1,
      ST_SETUP    = 3'd2,
      ST_ACCESS   = 3'd3,
      ST_RESP     = 3'd4
   } state_t;

   // Register offset addressed by an op; the illegal op never reaches the bus.
   function automatic logic [7:0] op_offset(input logic [1:0] op);
      case (op)
         OP_BAUD: op_offset = REG_BAUD;
         OP_TX:   op_offset = REG_TX;
         OP_RX:   op_offset = REG_RX;
         default: op_offset = 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/apb_uart_sched_rr_arb2.sv
// Two-way round-robin arbiter. On a tie the requester that did not win
// last time is granted; a lone requester always wins.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   input  logic       en,
   output logic [1:0] gnt,
   output logic       idx
);

   // Pick the winner index, then form the one-hot grant when enabled.
   always_comb begin
      idx = 1'b0;
      case (req)
         2'b01:   idx = 1'b0;
         2'b10:   idx = 1'b1;
         2'b11:   idx = ~last;
         default: idx = 1'b0;
      endcase
      gnt = 2'b00;
      if (en && (req != 2'b00)) begin
         gnt = idx ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/apb_uart_sched.sv
// Two-requester APB master for the UART register slave. Commands are
// arbitrated round-robin, gated on the UART ready status, run as a
// SETUP/ACCESS APB transfer and answered with a one-cycle response.
//
// Handshake: a requester holds req_valid/op/wdata stable until it sees
// req_ready for its bit; req_ready is a combinational one-cycle accept that
// can only be high in IDLE. rsp_valid is a one-cycle strobe with no
// back-pressure; rsp_rdata and rsp_err are meaningful only while it is high.
module apb_uart_sched
   import apb_uart_pkg::*;
#(
   parameter int BITWIDTH = DEF_BITWIDTH,
   parameter int ADDR_W   = 32,
   parameter int TIMEOUT  = 255
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic [1:0]            req_valid,
   input  logic [3:0]            req_op,
   input  logic [2*BITWIDTH-1:0] req_wdata,
   output logic [1:0]            req_ready,
   output logic [1:0]            rsp_valid,
   output logic [BITWIDTH-1:0]   rsp_rdata,
   output logic                  rsp_err,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_W-1:0]     paddr,
   output logic [BITWIDTH-1:0]   pwdata,
   input  logic                  pready,
   input  logic [BITWIDTH-1:0]   prdata,
   input  logic                  tx_rdy,
   input  logic                  rx_rdy,
   output logic [2:0]            dbg_state
);

   // Last value the wait counter takes before the error path fires, so
   // TIMEOUT=N allows exactly N wait cycles.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t                state, state_nx;
   logic [1:0]            op_q;
   logic [BITWIDTH-1:0]   wdata_q;
   logic [BITWIDTH-1:0]   rdata_q;
   logic                  idx_q;
   logic                  last_grant;
   logic                  err_q;
   logic [7:0]            wait_cnt;

   logic [1:0]            gnt;
   logic                  win;
   logic [1:0]            win_op;
   logic [BITWIDTH-1:0]   win_wdata;
   logic                  gate_ok;
   logic                  wait_done;
   logic                  any_req;

   // Arbitration is only enabled in IDLE and outside reset.
   rr_arb2 u_arb (
      .req  (req_valid),
      .last (last_grant),
      .en   ((state == ST_IDLE) && presetn),
      .gnt  (gnt),
      .idx  (win)
   );

   assign any_req   = |req_valid;
   assign win_op    = win ? req_op[3:2] : req_op[1:0];
   assign win_wdata = win ? req_wdata[2*BITWIDTH-1:BITWIDTH] : req_wdata[BITWIDTH-1:0];
   assign gate_ok   = (op_q == OP_TX) ? tx_rdy : rx_rdy;
   assign wait_done = (wait_cnt == WAIT_LAST);

   // State register.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) state <= ST_IDLE;
      else          state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (any_req) begin
               case (win_op)
                  OP_BAUD:      state_nx = ST_SETUP;
                  OP_TX, OP_RX: state_nx = ST_WAIT_RDY;
                  default:      state_nx = ST_RESP;
               endcase
            end
         end
         ST_WAIT_RDY: begin
            if (gate_ok)        state_nx = ST_SETUP;
            else if (wait_done) state_nx = ST_RESP;
         end
         ST_SETUP:  state_nx = ST_ACCESS;
         ST_ACCESS: begin
            if (pready || wait_done) state_nx = ST_RESP;
         end
         ST_RESP:   state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   // Wait counter runs only in WAIT_RDY and ACCESS; every entry to either
   // comes from a state where it is held at zero.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) wait_cnt <= 8'd0;
      else if ((state == ST_WAIT_RDY) || (state == ST_ACCESS)) wait_cnt <= wait_cnt + 8'd1;
      else wait_cnt <= 8'd0;
   end

   // Command latch, grant history, captured read data and error flag.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         op_q       <= 2'b00;
         wdata_q    <= '0;
         rdata_q    <= '0;
         idx_q      <= 1'b0;
         last_grant <= 1'b1;
         err_q      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  op_q       <= win_op;
                  wdata_q    <= win_wdata;
                  idx_q      <= win;
                  last_grant <= win;
                  err_q      <= (win_op == OP_ILL);
                  rdata_q    <= '0;
               end
            end
            ST_WAIT_RDY: begin
               if (!gate_ok && wait_done) err_q <= 1'b1;
            end
            ST_ACCESS: begin
               if (pready) begin
                  if (op_q == OP_RX) rdata_q <= prdata;
               end else if (wait_done) begin
                  err_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from the current state and latched command.
   always_comb begin
      req_ready = gnt;
      rsp_valid = 2'b00;
      rsp_rdata = '0;
      rsp_err   = 1'b0;
      psel      = 1'b0;
      penable   = 1'b0;
      pwrite    = 1'b0;
      paddr     = '0;
      pwdata    = '0;
      dbg_state = state;
      case (state)
         ST_SETUP, ST_ACCESS: begin
            psel       = 1'b1;
            penable    = (state == ST_ACCESS);
            pwrite     = (op_q != OP_RX);
            paddr[7:0] = op_offset(op_q);
            pwdata     = (op_q == OP_RX) ? '0 : wdata_q;
         end
         ST_RESP: begin
            rsp_valid = idx_q ? 2'b10 : 2'b01;
            rsp_rdata = (op_q == OP_RX) ? rdata_q : '0;
            rsp_err   = err_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_apb_uart_sched.sv
// Directed bench for apb_uart_sched with hand-computed expectations.
module tb_apb_uart_sched;

   localparam int BW  = 8;
   localparam int AW  = 32;
   localparam int TMO = 10;

   logic          pclk = 1'b0;
   logic          presetn;
   logic [1:0]    req_valid;
   logic [3:0]    req_op;
   logic [2*BW-1:0] req_wdata;
   logic [1:0]    req_ready;
   logic [1:0]    rsp_valid;
   logic [BW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [BW-1:0] pwdata;
   logic          pready;
   logic [BW-1:0] prdata;
   logic          tx_rdy, rx_rdy;
   logic [2:0]    dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   // Scoreboard of expected APB write data, in order.
   logic [BW-1:0] exp_q[$];

   // Observations captured by wait_rsp.
   logic [AW-1:0] s_paddr;
   logic          s_pwrite;
   logic [BW-1:0] s_pwdata;
   int            n_psel, n_pen, n_unstable, lat;
   logic [1:0]    r_valid;
   logic [BW-1:0] r_rdata;
   logic          r_err;
   logic          r_psel;

   apb_uart_sched #(.BITWIDTH(BW), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
      .pclk      (pclk),
      .presetn   (presetn),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .pready    (pready),
      .prdata    (prdata),
      .tx_rdy    (tx_rdy),
      .rx_rdy    (rx_rdy),
      .dbg_state (dbg_state)
   );

   // Clock: 10 time-unit period.
   always #5 pclk = ~pclk;

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      presetn   = 1'b0;
      req_valid = 2'b00;
      req_op    = 4'b0;
      req_wdata = '0;
      pready    = 1'b0;
      tx_rdy    = 1'b0;
      rx_rdy    = 1'b0;
      prdata    = 8'hC3;
      tick();
      tick();
      presetn = 1'b1;
      #1;
   endtask

   // Present one command, check the accept strobe, advance to cycle 1.
   task automatic issue(input int r, input logic [1:0] op, input logic [7:0] wd,
                        input logic [1:0] exp_rdy);
      req_valid[r]       = 1'b1;
      req_op[2*r +: 2]   = op;
      req_wdata[8*r +: 8] = wd;
      #1;
      check("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
      tick();
      req_valid[r] = 1'b0;
   endtask

   // Drive status/pready per cycle after accept and watch the bus until a
   // response appears. Status rises once more than rdy_delay cycles have
   // passed; pready rises after pready_delay ACCESS cycles.
   task automatic wait_rsp(input int rdy_delay, input int pready_delay);
      logic got;
      got = 1'b0;
      n_psel = 0; n_pen = 0; n_unstable = 0; lat = 0;
      r_valid = 2'b00; r_rdata = '0; r_err = 1'b0; r_psel = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         tx_rdy = (n > rdy_delay);
         rx_rdy = (n > rdy_delay);
         if (psel) n_psel++;
         if (psel && !penable) begin
            s_paddr  = paddr;
            s_pwrite = pwrite;
            s_pwdata = pwdata;
            if (pwrite && exp_q.size() > 0) check("apb_wdata_sb", {24'd0, pwdata}, {24'd0, exp_q.pop_front()});
         end
         if (penable) begin
            n_pen++;
            pready = (n_pen > pready_delay);
            if (paddr !== s_paddr || pwdata !== s_pwdata || pwrite !== s_pwrite) n_unstable++;
         end else begin
            pready = 1'b0;
         end
         #1;
         if (rsp_valid != 2'b00) begin
            lat = n; r_valid = rsp_valid; r_rdata = rsp_rdata; r_err = rsp_err; r_psel = psel;
            got = 1'b1;
            break;
         end
         tick();
      end
      tx_rdy = 1'b0; rx_rdy = 1'b0; pready = 1'b0;
      if (!got) check("rsp_seen", 32'd0, 32'd1);
   endtask

   initial begin
      int quiet;
      // Reset values while presetn is low.
      presetn = 1'b0; req_valid = 2'b00; req_op = 4'b0; req_wdata = '0;
      pready = 1'b0; tx_rdy = 1'b0; rx_rdy = 1'b0; prdata = 8'hC3;
      #2;
      check("rst_psel",    {31'd0, psel}, 32'd0);
      check("rst_penable", {31'd0, penable}, 32'd0);
      check("rst_pwrite",  {31'd0, pwrite}, 32'd0);
      check("rst_paddr",   paddr, 32'd0);
      check("rst_pwdata",  {24'd0, pwdata}, 32'd0);
      check("rst_rsp",     {21'd0, rsp_valid, rsp_rdata, rsp_err}, 32'd0);
      check("rst_state",   {29'd0, dbg_state}, 32'd0);
      req_valid = 2'b11; #1;
      check("rst_req_ready", {30'd0, req_ready}, 32'd0);
      do_reset();

      // BAUD from requester 0, pready high on first ACCESS cycle.
      issue(0, 2'b00, 8'h1A, 2'b01);
      wait_rsp(0, 0);
      check("baud_lat",    lat, 32'd3);
      check("baud_paddr",  s_paddr, 32'h00);
      check("baud_pwrite", {31'd0, s_pwrite}, 32'd1);
      check("baud_pwdata", {24'd0, s_pwdata}, 32'h1A);
      check("baud_psel_n", n_psel, 32'd2);
      check("baud_pen_n",  n_pen, 32'd1);
      check("baud_rsp",    {22'd0, r_valid, r_rdata}, {22'd0, 2'b01, 8'h00});
      check("baud_err",    {31'd0, r_err}, 32'd0);
      tick();
      check("baud_rsp_one", {30'd0, rsp_valid}, 32'd0);

      // Back-to-back TX ties from both requesters.
      do_reset();
      exp_q.push_back(8'h55);
      exp_q.push_back(8'hAA);
      req_op = 4'b0101; req_wdata = {8'hAA, 8'h55}; req_valid = 2'b11; #1;
      check("tie1_ready", {30'd0, req_ready}, 32'b01);
      tick(); req_valid[0] = 1'b0;
      wait_rsp(0, 0);
      check("tx0_lat",   lat, 32'd4);
      check("tx0_paddr", s_paddr, 32'h04);
      check("tx0_rsp",   {30'd0, r_valid}, 32'b01);
      tick();
      check("tx1_ready", {30'd0, req_ready}, 32'b10);
      tick(); req_valid[1] = 1'b0;
      wait_rsp(0, 0);
      check("tx1_lat",   lat, 32'd4);
      check("tx1_paddr", s_paddr, 32'h04);
      check("tx1_rsp",   {30'd0, r_valid}, 32'b10);
      check("tx_sb_empty", exp_q.size(), 32'd0);
      tick();
      req_valid = 2'b11; #1;
      check("tie3_ready", {30'd0, req_ready}, 32'b01);
      tick(); req_valid = 2'b00;
      wait_rsp(0, 0);
      check("tie3_rsp", {30'd0, r_valid}, 32'b01);

      // RX: status low 5 cycles, pready after 2 ACCESS cycles.
      do_reset();
      issue(1, 2'b10, 8'h77, 2'b10);
      wait_rsp(5, 2);
      check("rx_lat",      lat, 32'd11);
      check("rx_pen_n",    n_pen, 32'd3);
      check("rx_paddr",    s_paddr, 32'h08);
      check("rx_pwrite",   {31'd0, s_pwrite}, 32'd0);
      check("rx_pwdata",   {24'd0, s_pwdata}, 32'd0);
      check("rx_stable",   n_unstable, 32'd0);
      check("rx_rsp",      {22'd0, r_valid, r_rdata}, {22'd0, 2'b10, 8'hC3});
      check("rx_err",      {31'd0, r_err}, 32'd0);

      // TX with tx_rdy stuck low: error after TMO wait cycles, no bus activity.
      tick();
      issue(0, 2'b01, 8'h11, 2'b01);
      wait_rsp(99, 0);
      check("txto_lat",    lat, 32'd11);
      check("txto_psel_n", n_psel, 32'd0);
      check("txto_rsp",    {22'd0, r_valid, r_rdata}, {22'd0, 2'b01, 8'h00});
      check("txto_err",    {31'd0, r_err}, 32'd1);

      // RX with pready stuck low: error after TMO ACCESS cycles, bus released.
      tick();
      issue(1, 2'b10, 8'h00, 2'b10);
      wait_rsp(0, 99);
      check("pto_lat",   lat, 32'd13);
      check("pto_pen_n", n_pen, 32'd10);
      check("pto_err",   {31'd0, r_err}, 32'd1);
      check("pto_psel",  {31'd0, r_psel}, 32'd0);
      check("pto_rsp",   {30'd0, r_valid}, 32'b10);

      // Illegal op: error response one cycle after accept, no bus.
      tick();
      issue(0, 2'b11, 8'h00, 2'b01);
      wait_rsp(0, 0);
      check("ill_lat",    lat, 32'd1);
      check("ill_psel_n", n_psel, 32'd0);
      check("ill_err",    {31'd0, r_err}, 32'd1);
      check("ill_rsp",    {30'd0, r_valid}, 32'b01);

      // Reset during ACCESS aborts the command; last_grant returns to 1.
      tick();
      issue(0, 2'b00, 8'h42, 2'b01);
      tick();
      check("abort_in_access", {30'd0, psel, penable}, 32'b11);
      presetn = 1'b0; #1;
      check("abort_bus_drop", {30'd0, psel, penable}, 32'b00);
      tick();
      presetn = 1'b1;
      quiet = 0;
      for (int i = 0; i < 6; i++) begin
         if (rsp_valid != 2'b00) quiet++;
         tick();
      end
      check("abort_no_rsp", quiet, 32'd0);
      req_op = 4'b0000; req_wdata = {8'h02, 8'h01}; req_valid = 2'b11; #1;
      check("abort_tie_ready", {30'd0, req_ready}, 32'b01);
      tick(); req_valid = 2'b00;
      wait_rsp(0, 0);
      check("abort_next_rsp", {30'd0, r_valid}, 32'b01);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
